// File: rtl/mul_cdb_buffer_pkg.sv
// Shared types and constants for the multiplier completion buffer.
// Consumed by mul_result_fifo and mul_cdb_buffer.
package mul_cdb_buffer_pkg;

    localparam int XLEN          = 32;
    localparam int PRF_LEN       = 6;
    localparam int ROB_LEN       = 5;
    localparam int STAGE         = 8;
    localparam int MUL_BUF_DEPTH = 8;
    localparam int MUL_BUF_LEN   = $clog2(MUL_BUF_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } MUL_RESULT_PACKET;

endpackage

// File: rtl/mul_result_fifo.sv
// Circular result store with head/tail/count bookkeeping and a single-cycle clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module mul_result_fifo
    import mul_cdb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  MUL_RESULT_PACKET             wr_data,
    output MUL_RESULT_PACKET             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    MUL_RESULT_PACKET   mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; count gates visibility of every entry.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= wr_data;
    end

    assign rd_data = mem[head];

endmodule

// File: rtl/mul_cdb_buffer.sv
// Buffers multiplier results for the CDB arbiter and throttles multiply issue.
// Optional same-cycle bypass of an arrival into an empty buffer: MUL_BUF_BYPASS_EN.
module mul_cdb_buffer
    import mul_cdb_buffer_pkg::*;
#(
    parameter int unsigned MUL_BUF_DEPTH = mul_cdb_buffer_pkg::MUL_BUF_DEPTH,
    parameter int unsigned MUL_LATENCY   = STAGE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mul_enable,
    input  logic               mul_valid,
    input  logic [XLEN-1:0]    mul_value,
    input  logic [PRF_LEN-1:0] mul_prf_idx,
    input  logic [ROB_LEN-1:0] mul_rob_idx,
    input  logic [XLEN-1:0]    mul_PC,
    input  logic               squash,
    input  logic               cdb_grant,
    output logic               cdb_req,
    output logic [XLEN-1:0]    cdb_value,
    output logic [PRF_LEN-1:0] cdb_prf_idx,
    output logic [ROB_LEN-1:0] cdb_rob_idx,
    output logic [XLEN-1:0]    cdb_PC,
    output logic               mul_issue_stall
);

    localparam int unsigned CNT_W = $clog2(MUL_BUF_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(MUL_LATENCY + 1);

    logic [CNT_W-1:0] count;
    logic [INF_W-1:0] inflight, inflight_next;
    logic [INF_W-1:0] drop_cnt, drop_cnt_next;
    logic             arrival_keep;
    logic             fifo_push;
    logic             fifo_pop;
    MUL_RESULT_PACKET arrival_pkt;
    MUL_RESULT_PACKET head_pkt;

    assign arrival_pkt.value   = mul_value;
    assign arrival_pkt.prf_idx = mul_prf_idx;
    assign arrival_pkt.rob_idx = mul_rob_idx;
    assign arrival_pkt.PC      = mul_PC;

    assign arrival_keep = mul_valid && (drop_cnt == '0) && !squash;
    assign fifo_pop     = (count != '0) && cdb_grant && !squash;

`ifdef MUL_BUF_BYPASS_EN
    logic bypass_fire;
    assign bypass_fire = arrival_keep && (count == '0);
    // A bypassed arrival that is granted immediately never occupies a slot.
    assign fifo_push   = arrival_keep && !(bypass_fire && cdb_grant);
`else
    assign fifo_push   = arrival_keep;
`endif

    mul_result_fifo #(
        .DEPTH   (MUL_BUF_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (squash),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (arrival_pkt),
        .rd_data (head_pkt),
        .count   (count)
    );

    assign inflight_next = inflight + INF_W'(mul_enable) - INF_W'(mul_valid);

    // On squash, everything still in the pipe (including this cycle's issue) is doomed.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (squash) begin
            drop_cnt_next = inflight_next;
        end else if (mul_valid && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - INF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    assign mul_issue_stall = (32'(count) + 32'(inflight)) >= MUL_BUF_DEPTH;

    always_comb begin
        cdb_req     = 1'b0;
        cdb_value   = '0;
        cdb_prf_idx = '0;
        cdb_rob_idx = '0;
        cdb_PC      = '0;
        if (count != '0) begin
            cdb_req     = 1'b1;
            cdb_value   = head_pkt.value;
            cdb_prf_idx = head_pkt.prf_idx;
            cdb_rob_idx = head_pkt.rob_idx;
            cdb_PC      = head_pkt.PC;
        end
`ifdef MUL_BUF_BYPASS_EN
        else if (bypass_fire) begin
            cdb_req     = 1'b1;
            cdb_value   = mul_value;
            cdb_prf_idx = mul_prf_idx;
            cdb_rob_idx = mul_rob_idx;
            cdb_PC      = mul_PC;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(fifo_push && !fifo_pop && (count == CNT_W'(MUL_BUF_DEPTH))));
            assert (!(mul_valid && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// Directed bench for mul_cdb_buffer with a fixed-latency multiplier stand-in.
// Expected results assume MUL_BUF_DEPTH = 8 and MUL_LATENCY = 8.
module tb_mul_cdb_buffer;
    import mul_cdb_buffer_pkg::*;

    localparam int unsigned LAT = 8;
`ifdef MUL_BUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               mul_enable;
    logic               mul_valid;
    logic [XLEN-1:0]    mul_value;
    logic [PRF_LEN-1:0] mul_prf_idx;
    logic [ROB_LEN-1:0] mul_rob_idx;
    logic [XLEN-1:0]    mul_PC;
    logic               squash;
    logic               cdb_grant;
    logic               cdb_req;
    logic [XLEN-1:0]    cdb_value;
    logic [PRF_LEN-1:0] cdb_prf_idx;
    logic [ROB_LEN-1:0] cdb_rob_idx;
    logic [XLEN-1:0]    cdb_PC;
    logic               mul_issue_stall;

    MUL_RESULT_PACKET   pipe_q [LAT];
    logic               pipe_v [LAT];
    MUL_RESULT_PACKET   issue_pkt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mul_cdb_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .mul_enable      (mul_enable),
        .mul_valid       (mul_valid),
        .mul_value       (mul_value),
        .mul_prf_idx     (mul_prf_idx),
        .mul_rob_idx     (mul_rob_idx),
        .mul_PC          (mul_PC),
        .squash          (squash),
        .cdb_grant       (cdb_grant),
        .cdb_req         (cdb_req),
        .cdb_value       (cdb_value),
        .cdb_prf_idx     (cdb_prf_idx),
        .cdb_rob_idx     (cdb_rob_idx),
        .cdb_PC          (cdb_PC),
        .mul_issue_stall (mul_issue_stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] v);
        mul_enable        = 1'b1;
        issue_pkt.value   = v;
        issue_pkt.prf_idx = v[PRF_LEN-1:0];
        issue_pkt.rob_idx = v[ROB_LEN-1:0];
        issue_pkt.PC      = 32'h1000 + v;
    endtask

    // Advance one clock; the multiplier model delivers an op LAT cycles after issue.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_q[i] = pipe_q[i-1];
        end
        pipe_v[0] = mul_enable & ~reset;
        pipe_q[0] = issue_pkt;
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
        end
        mul_valid   = pipe_v[LAT-1];
        mul_value   = pipe_q[LAT-1].value;
        mul_prf_idx = pipe_q[LAT-1].prf_idx;
        mul_rob_idx = pipe_q[LAT-1].rob_idx;
        mul_PC      = pipe_q[LAT-1].PC;
        mul_enable  = 1'b0;
        squash      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int nxt;
        int shown;

        reset = 1'b1; mul_enable = 1'b0; mul_valid = 1'b0; mul_value = '0;
        mul_prf_idx = '0; mul_rob_idx = '0; mul_PC = '0; squash = 1'b0; cdb_grant = 1'b0;
        issue_pkt = '0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_q[i] = '0;
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_req",   cdb_req, 0);
        check_eq("rst_stall", mul_issue_stall, 0);
        check_eq("rst_value", cdb_value, 0);
        check_eq("rst_prf",   cdb_prf_idx, 0);
        check_eq("rst_rob",   cdb_rob_idx, 0);
        check_eq("rst_pc",    cdb_PC, 0);

        // Single result, grant tied high
        next_cycle();
        issue(32'h6);
        issue_pkt.rob_idx = 5'd3;
        cdb_grant = 1'b1;
        for (int w = 0; w < 20 && !mul_valid; w++) next_cycle();
        check_eq("single_arrive", mul_valid, 1);
        @(negedge clock);
        check_eq("single_req_t",   cdb_req, BYPASS);
        check_eq("single_val_t",   cdb_value, BYPASS ? 64'h6 : 64'h0);
        next_cycle();
        @(negedge clock);
        check_eq("single_req_t1",  cdb_req, !BYPASS);
        check_eq("single_val_t1",  cdb_value, BYPASS ? 64'h0 : 64'h6);
        check_eq("single_rob_t1",  cdb_rob_idx, BYPASS ? 64'h0 : 64'h3);
        next_cycle();
        @(negedge clock);
        check_eq("single_req_t2",  cdb_req, 0);
        cdb_grant = 1'b0;

        // Backpressure fill: RS issues whenever not stalled
        issued = 0;
        for (int c = 0; c < 24; c++) begin
            next_cycle();
            if (!mul_issue_stall) begin
                issued++;
                issue(issued);
            end
        end
        @(negedge clock);
        check_eq("fill_issued", issued, 8);
        check_eq("fill_stall",  mul_issue_stall, 1);
        check_eq("fill_req",    cdb_req, 1);
        check_eq("fill_head",   cdb_value, 1);

        // Full: pop one, refill with one new op
        next_cycle();
        cdb_grant = 1'b1;
        @(negedge clock);
        check_eq("full_pop_head", cdb_value, 1);
        next_cycle();
        cdb_grant = 1'b0;
        check_eq("full_stall_7", mul_issue_stall, 0);
        issue(9);
        @(negedge clock);
        check_eq("full_head_2", cdb_value, 2);
        next_cycle();
        @(negedge clock);
        check_eq("full_stall_7p1", mul_issue_stall, 1);
        for (int w = 0; w < 10; w++) next_cycle();
        cdb_grant = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clock);
            check_eq("drain_req", cdb_req, 1);
            check_eq("drain_val", cdb_value, k);
            check_eq("drain_pc",  cdb_PC, 32'h1000 + k);
            next_cycle();
        end
        @(negedge clock);
        check_eq("drain_empty", cdb_req, 0);
        check_eq("drain_stall", mul_issue_stall, 0);
        cdb_grant = 1'b0;

        // Squash with count=2, inflight=3 and a same-cycle issue
        issue(32'h20);
        next_cycle();
        issue(32'h21);
        for (int w = 0; w < 11; w++) next_cycle();
        issue(32'h30);
        next_cycle();
        issue(32'h31);
        next_cycle();
        issue(32'h32);
        next_cycle();
        issue(32'h33);
        squash = 1'b1;
        @(negedge clock);
        check_eq("sq_same_req", cdb_req, 1);
        check_eq("sq_same_val", cdb_value, 32'h20);
        next_cycle();
        @(negedge clock);
        check_eq("sq_next_req", cdb_req, 0);
        issue(32'h40);
        cdb_grant = 1'b1;
        shown = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            @(negedge clock);
            if (cdb_req) begin
                shown++;
                check_eq("sq_survivor", cdb_value, 32'h40);
            end
        end
        check_eq("sq_shown", shown, 1);

        // Pointer wrap with random grants
        nxt = 0;
        issued = 0;
        for (int c = 0; c < 400 && nxt < 20; c++) begin
            next_cycle();
            if (!mul_issue_stall && issued < 20) begin
                issue(issued);
                issued++;
            end
            cdb_grant = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (cdb_req && cdb_grant) begin
                check_eq("wrap_order", cdb_value, nxt);
                nxt++;
            end
        end
        check_eq("wrap_count", nxt, 20);

        // Reset mid-operation
        next_cycle();
        cdb_grant = 1'b0;
        issue(32'h50);
        next_cycle();
        issue(32'h51);
        next_cycle();
        issue(32'h52);
        for (int w = 0; w < 10; w++) next_cycle();
        @(negedge clock);
        check_eq("mid_pre_req", cdb_req, 1);
        issue(32'h53);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_req",   cdb_req, 0);
        check_eq("mid_rst_stall", mul_issue_stall, 0);
        check_eq("mid_rst_val",   cdb_value, 0);
        for (int w = 0; w < 12; w++) next_cycle();
        @(negedge clock);
        check_eq("mid_rst_quiet", cdb_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_cdb_buffer.md
# mul_cdb_buffer

Receiving end of the multiplier's completion stream. The pipelined multiplier `mult2cdb` has no stall input and emits one result per `mul_valid` pulse. This block captures each result into a FIFO and presents the oldest one to the CDB arbiter with a request/grant handshake. It throttles multiply issue in the RS so that results can never overflow the FIFO, and on a squash it discards all buffered results and every result still inside the multiplier pipeline.

## Interface
Parameters:
- `MUL_BUF_DEPTH`, default 8: FIFO entries; must be a power of 2 and ≥ 2.
- `MUL_LATENCY`, default 8: multiplier pipeline depth, equal to `STAGE`; used only to size the in-flight counter.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `mul_enable` in 1: RS issues one multiply this cycle; the same signal drives the multiplier's `start`.
- `mul_valid` in 1: multiplier result arrives this cycle.
- `mul_value` in `XLEN`: arriving result value.
- `mul_prf_idx` in `PRF_LEN`: arriving destination physical register.
- `mul_rob_idx` in `ROB_LEN`: arriving ROB index.
- `mul_PC` in `XLEN`: arriving PC.
- `squash` in 1: branch mispredict flush.
- `cdb_grant` in 1: arbiter accepts the current head this cycle; it is only meaningful while `cdb_req` is high.
- `cdb_req` out 1: head result is valid.
- `cdb_value` out `XLEN`: head result value.
- `cdb_prf_idx` out `PRF_LEN`: head destination physical register.
- `cdb_rob_idx` out `ROB_LEN`: head ROB index.
- `cdb_PC` out `XLEN`: head PC.
- `mul_issue_stall` out 1: RS must not assert `mul_enable` while this is high.

## Operation
State, all registers:
- `head` and `tail` pointers, each `log2(DEPTH)` bits, wrapping modulo DEPTH.
- `count`, 0..DEPTH.
- `inflight`, 0..`MUL_LATENCY`: ops currently in the multiplier.
- `drop_cnt`: the oldest in-flight ops that are already squashed.

Per-cycle rules:
- **Push:** `mul_valid && drop_cnt==0 && !squash` writes the arrival at `tail`, then `tail++`.
- **Drop:** `mul_valid && drop_cnt>0 && !squash` does not write; `drop_cnt--`.
- **Pop:** `cdb_req && cdb_grant && !squash` advances `head`.
- **Push and pop in the same cycle:** `count` is unchanged. This is legal when full, because the pop slot is freed.
- **`inflight` update:** `inflight_next = inflight + mul_enable - mul_valid`. This applies in every cycle, including squash cycles.
- **Squash:**
  - `head`, `tail` and `count` go to 0.
  - `drop_cnt_next = inflight + mul_enable - mul_valid`, so every op still in the pipe, including one issued this very cycle, is discarded on arrival.
  - A squash that arrives while drops are already pending uses the same formula.
- **Stall:** `mul_issue_stall = (count + inflight) >= MUL_BUF_DEPTH`, combinational from registers only. This keeps `count + inflight ≤ DEPTH`, so a push into a full FIFO cannot occur.
  - The stall is conservative: ops pending drop still count toward `inflight`.
- **Outputs:**
  - `cdb_req = (count != 0)`.
  - `cdb_*` are driven from the entry at `head`.
  - When `cdb_req` is low, `cdb_*` are held at 0.
- **Protocol violations:** pushing when full, or `mul_valid` with `inflight == 0`. Both are errors, and the implementation includes simulation-only assertions for them.

## Timing
- Reset values:
  - `cdb_req` = 0 and `mul_issue_stall` = 0.
  - All `cdb_*` = 0.
  - `count`, `inflight`, `drop_cnt`, `head` and `tail` = 0.
- Latency: result arrives in cycle t → `cdb_req` is high and the head is valid in t+1.
- The head stays stable while `cdb_req` is high and `cdb_grant` is low.
- After a grant in cycle t, the next entry appears in t+1.
- Throughput: one result per cycle in and one per cycle out.
- Squash in cycle t: `cdb_req` = 0 from t+1. The squash has no effect on outputs within cycle t itself.
- Reset mid-operation clears all state. The multiplier is reset at the same time, so no stale arrivals follow.

## Configuration
- `MUL_BUF_BYPASS_EN`:
  - **Defined:** when `count==0 && mul_valid && drop_cnt==0 && !squash`, `cdb_req` and `cdb_*` are driven combinationally from `mul_*` in the same cycle. If `cdb_grant` is high in that cycle, the arrival is not written to the FIFO. Latency becomes 0 cycles.
  - **Undefined:** purely registered output with 1-cycle latency. `cdb_*` depend only on registers.

## Structure
- The shared package holds:
  - the `MUL_RESULT_PACKET` struct (`value`, `prf_idx`, `rob_idx`, `PC`), which the FIFO stores;
  - the constants `MUL_BUF_DEPTH` and `MUL_BUF_LEN = $clog2(MUL_BUF_DEPTH)`.
- One sub-module, `mul_result_fifo`: storage array with the head/tail/count logic, plus push, pop and clear ports.
- The top level holds the `inflight`/`drop_cnt` accounting, the stall logic and the bypass mux.

## Test plan
- **Single result:** issue one op; arrival `mul_valid`, `value=32'h0000_0006`, `rob_idx=3`; `cdb_grant` tied high. → `cdb_req` pulses for one cycle in the cycle after arrival with `cdb_value=6` and `cdb_rob_idx=3`.
- **Backpressure fill:** `cdb_grant` held low; the RS issues every cycle while not stalled, giving 8 arrivals with values 1..8. → `mul_issue_stall` rises once `count + inflight` reaches 8. No further `mul_enable` occurs. Releasing the grant drains 1..8 in order.
- **Simultaneous push/pop at full:** `count=8`; `mul_enable` was suppressed, so no arrival is possible. Grant one entry and issue one op. → `count` goes to 7, then back to 8 when the op arrives. Order is preserved.
- **Squash with in-flight ops:** `count=2`, `inflight=3`, and `squash` is asserted in the same cycle as a `mul_enable`. → `cdb_req` = 0 the next cycle. The next 4 arrivals are dropped and never shown. The 5th op, issued after the squash, appears normally.
- **Pointer wrap:** 20 sequential results with values 0..19 and a random grant pattern. → Output order is exactly 0..19 and no entry is lost across the `head`/`tail` wrap.
- **Bypass (with `MUL_BUF_BYPASS_EN`):** empty FIFO, `mul_valid` with `value=32'hdead_beef`, `cdb_grant` high. → `cdb_req` and `cdb_value=32'hdead_beef` in the same cycle, and `count` stays 0.
